// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: control FSM
// encoding and default parameter values.
package regfile_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NRD      = 2;
  localparam int DEF_ZERO_REG = 1;
  localparam int DEF_BYPASS   = 1;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read lane: array select, same-cycle write forwarding,
// zero-register force and INIT force.
module regfile_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [(2**ADDR_W)*DATA_W-1:0] mem_flat,
  input  logic                          ready,
  input  logic [1:0]                    wr_en,
  input  logic [2*ADDR_W-1:0]           wr_addr,
  input  logic [2*DATA_W-1:0]           wr_data,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]             rd_data
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] entry [DEPTH];

  for (genvar j = 0; j < DEPTH; j++) begin : g_unpack
    assign entry[j] = mem_flat[j*DATA_W +: DATA_W];
  end

  always_comb begin
    // NOTE: rd_data gets a default before any conditional override so no latch is inferred.
    rd_data = entry[rd_addr];
    if (BYPASS != 0 && ready) begin
      // Ascending loop order lets port 1 override port 0 on a double hit.
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] == rd_addr)
          rd_data = wr_data[k*DATA_W +: DATA_W];
      end
    end
    // Applied last so a forwarded write to entry 0 or during INIT never leaks out.
    if (ZERO_REG != 0 && rd_addr == '0) rd_data = '0;
    if (!ready) rd_data = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NRD-read register file that clears itself with a one-entry-per-cycle
// sweep after reset before accepting writes.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            wr_en,
  input  logic [2*ADDR_W-1:0]   wr_addr,
  input  logic [2*DATA_W-1:0]   wr_data,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic                  init_busy
);

  localparam int DEPTH = 2**ADDR_W;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_idx, clr_idx_nxt;
  logic                ready;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state   <= ST_INIT;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      ST_INIT: begin
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == ADDR_W'(DEPTH-1)) begin
          state_nxt   = ST_READY;
          clr_idx_nxt = '0;
        end
      end
      ST_READY: ;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    init_busy = (state == ST_INIT);
    ready     = (state == ST_READY);
  end

  // NOTE: the array has no reset; it is cleared only by the INIT sweep, which keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[clr_idx] <= '0;
    end else begin
      // Port 1 is assigned last, so it wins a same-address collision.
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k] && !(ZERO_REG != 0 && wr_addr[k*ADDR_W +: ADDR_W] == '0))
          mem[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign mem_flat[i*DATA_W +: DATA_W] = mem[i];
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rdport (
      .mem_flat (mem_flat),
      .ready    (ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr[i*ADDR_W +: ADDR_W]),
      .rd_data  (rd_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, random traffic
// against an array-based reference model, and reset/INIT corner sequences.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          wr_en;
  logic [2*AW-1:0]     wr_addr;
  logic [2*DW-1:0]     wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*DW-1:0]   rd_data;
  logic                init_busy;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NRD      (NRD),
    .ZERO_REG (1),
    .BYPASS   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .init_busy (init_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural contents plus a countdown of INIT cycles.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_ready;
  int            m_init_left;

  typedef struct {
    logic [1:0]    en;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] e0, e1;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_ready     = 1'b0;
    m_init_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] ra);
    if (!m_ready || ra == 0) return '0;
    if (wr_en[1] && wr_addr[AW +: AW] == ra) return wr_data[DW +: DW];
    if (wr_en[0] && wr_addr[0 +: AW] == ra)  return wr_data[0 +: DW];
    return m_mem[ra];
  endfunction

  task automatic m_edge();
    if (!m_ready) begin
      m_init_left--;
      if (m_init_left == 0) m_ready = 1'b1;
    end else begin
      if (wr_en[0] && wr_addr[0 +: AW] != 0)  m_mem[wr_addr[0 +: AW]]  = wr_data[0 +: DW];
      if (wr_en[1] && wr_addr[AW +: AW] != 0) m_mem[wr_addr[AW +: AW]] = wr_data[DW +: DW];
    end
  endtask

  task automatic drive(input logic [1:0] en, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                       input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    wr_en   = en;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    rd_addr = {ra1, ra0};
  endtask

  // One clock: drive, check lanes against the model mid-cycle, then commit at the edge.
  task automatic model_cycle(input string tag, input logic [1:0] en, input logic [AW-1:0] wa0,
                             input logic [AW-1:0] wa1, input logic [DW-1:0] wd0,
                             input logic [DW-1:0] wd1, input logic [AW-1:0] ra0,
                             input logic [AW-1:0] ra1);
    drive(en, wa0, wa1, wd0, wd1, ra0, ra1);
    #2;
    check({tag, "_lane0"}, rd_data[0 +: DW], m_read(ra0));
    check({tag, "_lane1"}, rd_data[DW +: DW], m_read(ra1));
    check({tag, "_busy"}, DW'(init_busy), DW'(!m_ready));
    @(posedge clk);
    m_edge();
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom);
  endfunction

  task automatic rand_cycle(input string tag, input bit hit_34);
    if (hit_34)
      model_cycle(tag, 2'b11, 5'd3, 5'd4, $urandom, $urandom, 5'd3, 5'd4);
    else
      model_cycle(tag, 2'($urandom), rand_addr(), rand_addr(), $urandom, $urandom,
                  rand_addr(), rand_addr());
  endtask

  // Runs until init_busy drops, bounded; returns the number of busy cycles seen.
  task automatic run_init(input string tag, input bit hit_34, output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 64) begin
      rand_cycle(tag, hit_34);
      n++;
    end
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      drive(2'b00, '0, '0, '0, '0, AW'(i), AW'(DEPTH-1-i));
      #2;
      check({tag, "_lane0"}, rd_data[0 +: DW], '0);
      check({tag, "_lane1"}, rd_data[DW +: DW], '0);
      @(posedge clk);
      m_edge();
      #1;
    end
  endtask

  initial begin
    vec_t vecs[$];
    int   n_busy;

    vecs = '{
      '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        5'd5, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF},
      '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        5'd5, 5'd7,  32'hDEADBEEF, 32'h0},
      '{2'b11, 5'd7, 5'd7, 32'h11111111, 32'h22222222, 5'd7, 5'd7,  32'h22222222, 32'h22222222},
      '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        5'd7, 5'd5,  32'h22222222, 32'hDEADBEEF},
      '{2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,        32'h0},
      '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        5'd0, 5'd0,  32'h0,        32'h0},
      '{2'b10, 5'd9, 5'd9, 32'h12345678, 32'hA5A5A5A5, 5'd9, 5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5},
      '{2'b01, 5'd9, 5'd0, 32'h0BADF00D, 32'hFFFFFFFF, 5'd9, 5'd0,  32'h0BADF00D, 32'h0},
      '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        5'd9, 5'd31, 32'h0BADF00D, 32'h0}
    };

    rst = 1'b1;
    drive(2'b00, '0, '0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", DW'(init_busy), 32'd1);
    check("reset_lane0", rd_data[0 +: DW], '0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    run_init("init1", 1'b0, n_busy);
    check("init1_len", DW'(n_busy), 32'd32);
    sweep_zero("clear1");

    foreach (vecs[v]) begin
      drive(vecs[v].en, vecs[v].wa0, vecs[v].wa1, vecs[v].wd0, vecs[v].wd1, vecs[v].ra0, vecs[v].ra1);
      #2;
      check($sformatf("vec%0d_lane0", v), rd_data[0 +: DW], vecs[v].e0);
      check($sformatf("vec%0d_lane1", v), rd_data[DW +: DW], vecs[v].e1);
      @(posedge clk);
      m_edge();
      #1;
    end

    for (int i = 0; i < 400; i++) rand_cycle("rand", 1'b0);

    // Partial INIT with ignored writes, then a second reset at clr_idx = 10.
    rst = 1'b1;
    #1;
    check("rst2_busy", DW'(init_busy), 32'd1);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) rand_cycle("init2", 1'b1);
    rst = 1'b1;
    #1;
    check("rst3_busy", DW'(init_busy), 32'd1);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_init("init3", 1'b1, n_busy);
    check("init3_len", DW'(n_busy), 32'd32);
    sweep_zero("clear3");

    for (int i = 0; i < 100; i++) rand_cycle("rand2", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NRD, default 2, number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and is never written.
REQ-005 Parameter BYPASS, default 1; when 1, same-cycle writes forward to matching reads.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 wr_en  in  2  per-write-port enable; bit k enables write port k.
REQ-009 wr_addr  in  2*ADDR_W  write addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-010 wr_data  in  2*DATA_W  write data; port k at bits [k*DATA_W +: DATA_W].
REQ-011 rd_addr  in  NRD*ADDR_W  read addresses, same packing as wr_addr.
REQ-012 rd_data  out  NRD*DATA_W  read data, same packing as wr_data.
REQ-013 init_busy  out  1  high while the clear sequence runs; file not usable.

Function
REQ-014 Control FSM SHALL have two states: INIT (clearing) and READY.
REQ-015 In INIT, a counter clr_idx SHALL write zero to entry clr_idx each cycle, incrementing by 1 per cycle from 0.
REQ-016 When clr_idx = DEPTH-1 is cleared, the FSM SHALL move to READY on that same edge; INIT lasts exactly DEPTH cycles.
REQ-017 init_busy SHALL equal 1 in INIT and 0 in READY (registered state decode, no glitching).
REQ-018 In INIT, all wr_en SHALL be ignored and every rd_data lane SHALL read 0.
REQ-019 In READY, write port k SHALL store wr_data[k] into entry wr_addr[k] on the rising edge when wr_en[k] = 1.
REQ-020 Both ports writing the same address in one cycle: port 1 data SHALL be stored; port 0 write discarded.
REQ-021 ZERO_REG = 1: writes to address 0 SHALL be dropped; reads of address 0 SHALL return 0 regardless of BYPASS.
REQ-022 Reads SHALL be combinational: rd_data lane i = entry rd_addr[i], zero-cycle latency.
REQ-023 BYPASS = 0: a write becomes visible on read ports from the cycle after the write edge.
REQ-024 BYPASS = 1 and READY: if an enabled write port addresses rd_addr[i] in the same cycle, lane i SHALL return that wr_data; port 1 has priority over port 0.
REQ-025 Bypass SHALL NOT apply to dropped writes (address 0 with ZERO_REG = 1, or INIT state).
REQ-026 All NRD read ports SHALL be independent; any number may address the same entry.

Reset
REQ-027 rst assertion SHALL immediately force state INIT, clr_idx = 0, init_busy = 1, regardless of current state.
REQ-028 rst asserted mid-INIT SHALL restart clearing from entry 0.
REQ-029 Array storage itself SHALL NOT be reset asynchronously; clearing occurs only through the INIT sweep.
REQ-030 After rst deassertion, first clear write SHALL occur on the first rising edge with rst low.

Structure
REQ-031 Package regfile_pkg SHALL hold the FSM state encoding (INIT, READY) and default parameter constants.
REQ-032 One sub-module regfile_rdport SHALL implement a single read lane (array select, zero-reg force, bypass mux, INIT force); instantiated NRD times by generate.
REQ-033 Clear FSM, counter and write logic SHALL reside in regfile_mp.

Verification
REQ-034 Reset, defaults: rst pulse then release -> init_busy high exactly 32 cycles, then 0; all 32 entries read 0.
REQ-035 Write then read: READY, wr_en=01, addr 5, data 0xDEADBEEF -> next cycle rd_addr[0]=5 returns 0xDEADBEEF; with BYPASS=1 also returned in the write cycle.
REQ-036 Write collision: both ports addr 7, port0 0x11111111, port1 0x22222222 -> entry 7 = 0x22222222; same-cycle bypass returns 0x22222222.
REQ-037 Zero register: write 0xFFFFFFFF to addr 0 -> both lanes reading addr 0 return 0 in the write cycle and after.
REQ-038 Reset mid-INIT: assert rst at clr_idx = 10 after entries hold data -> init_busy stays high 32 more cycles after release; all entries 0 afterward.
REQ-039 Writes during INIT: wr_en=11 to addrs 3 and 4 during INIT -> ignored; both read 0 after READY.
